// File: rtl/dot_product_mac_if.sv
// Stream/result bundle for the dot_product_mac engine: operand handshake, bias/start
// control, and the rounded result with its valid pulse and saturation flag.
interface dot_product_mac_if #(
  parameter int BIT_WIDTH = 16
) ();
  logic                 start;
  logic [BIT_WIDTH-1:0] bias;
  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_WIDTH-1:0] x_in;
  logic [BIT_WIDTH-1:0] w_in;
  logic                 busy;
  logic [BIT_WIDTH-1:0] out;
  logic                 out_valid;
  logic                 sat;

  modport master (
    output start, bias, in_valid, x_in, w_in,
    input  in_ready, busy, out, out_valid, sat
  );

  modport slave (
    input  start, bias, in_valid, x_in, w_in,
    output in_ready, busy, out, out_valid, sat
  );
endinterface

// File: rtl/dot_product_mac.sv
// Signed fixed-point MAC for one dense-layer neuron: bias + sum of VEC_LEN x*w products,
// rounded half-up and saturated to BIT_WIDTH, presented with a one-cycle out_valid pulse.
module dot_product_mac #(
  parameter int BIT_WIDTH = 16,
  parameter int FRAC_BITS = 8,
  parameter int VEC_LEN   = 8,
  parameter int ACC_WIDTH = 40
) (
  input logic              clk,
  input logic              rst_n,
  dot_product_mac_if.slave bus
);

  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

  localparam logic signed [ACC_WIDTH-1:0] HALF    = ACC_WIDTH'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = (ACC_WIDTH'(1) << (BIT_WIDTH - 1)) - ACC_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -(ACC_WIDTH'(1) << (BIT_WIDTH - 1));

  typedef enum logic [1:0] {IDLE, ACCUM, ROUND} state_t;

  state_t                        state;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic        [CNT_W-1:0]       count;

  logic signed [2*BIT_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]   prod_ext;
  logic signed [ACC_WIDTH-1:0]   bias_ext;
  logic signed [ACC_WIDTH-1:0]   rnd_sum;
  logic signed [ACC_WIDTH-1:0]   r_full;
  logic        [BIT_WIDTH-1:0]   r_clip;
  logic                          r_sat;

  assign bus.in_ready = (state == ACCUM);
  assign bus.busy     = (state == ACCUM) || (state == ROUND);

  always_comb begin
    prod     = $signed(bus.x_in) * $signed(bus.w_in);
    prod_ext = {{(ACC_WIDTH - 2*BIT_WIDTH){prod[2*BIT_WIDTH-1]}}, prod};
    bias_ext = {{(ACC_WIDTH - BIT_WIDTH){bus.bias[BIT_WIDTH-1]}}, bus.bias} << FRAC_BITS;
    // Adding half an LSB before the arithmetic shift gives round-half-toward-+inf.
    rnd_sum  = acc + HALF;
    r_full   = rnd_sum >>> FRAC_BITS;
    r_sat    = 1'b0;
    r_clip   = r_full[BIT_WIDTH-1:0];
    if (r_full > SAT_MAX) begin
      r_clip = SAT_MAX[BIT_WIDTH-1:0];
      r_sat  = 1'b1;
    end else if (r_full < SAT_MIN) begin
      r_clip = SAT_MIN[BIT_WIDTH-1:0];
      r_sat  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      acc           <= '0;
      count         <= '0;
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
      bus.sat       <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            acc   <= bias_ext;
            count <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (bus.in_valid) begin
            acc   <= acc + prod_ext;
            count <= count + 1'b1;
            if (count == LAST) state <= ROUND;
          end
        end
        ROUND: begin
          bus.out       <= r_clip;
          bus.sat       <= r_sat;
          bus.out_valid <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_mac.sv
// Directed-vector bench for dot_product_mac with hand-computed Q8.8 results.
module tb_dot_product_mac;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   cyc;

  dot_product_mac_if #(.BIT_WIDTH(16)) bus ();

  dot_product_mac #(
    .BIT_WIDTH(16),
    .FRAC_BITS(8),
    .VEC_LEN  (8),
    .ACC_WIDTH(40)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a negedge with the DUT idle (or in its out_valid cycle); returns at the
  // negedge of the out_valid cycle. A start pulse with a different bias is injected
  // during the second stall to prove start is ignored mid-ACCUM.
  task automatic run_op(input string tag, input logic [15:0] b,
                        input logic [7:0][15:0] xs, input logic [7:0][15:0] ws,
                        input int stall, input logic [15:0] exp_out, input logic exp_sat);
    bus.start = 1'b1;
    bus.bias  = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bias  = 16'h7F00;
    check({tag, "_ready_accum"}, 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      for (int s = 0; s < stall; s++) begin
        bus.in_valid = 1'b0;
        bus.x_in     = 16'h1234;
        bus.w_in     = 16'h4321;
        bus.start    = (i == 1);
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_stall_ready"}, 32'(bus.in_ready), 32'd1);
      end
      bus.in_valid = 1'b1;
      bus.x_in     = xs[i];
      bus.w_in     = ws[i];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check({tag, "_round_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_round_busy"},  32'(bus.busy),     32'd1);
    check({tag, "_round_ovld"},  32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_ovld"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_out"},  32'(bus.out),       32'(exp_out));
    check({tag, "_sat"},  32'(bus.sat),       32'(exp_sat));
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_pulse_end(input string tag, input logic [15:0] exp_out);
    @(negedge clk);
    check({tag, "_ovld_low"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_hold"}, 32'(bus.out),       32'(exp_out));
  endtask

  logic [7:0][15:0] xv;
  logic [7:0][15:0] wv;
  int               t_first;

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    cyc          = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.bias     = '0;
    bus.in_valid = 1'b0;
    bus.x_in     = '0;
    bus.w_in     = '0;
    repeat (2) @(negedge clk);
    check("rst_out",   32'(bus.out),       32'd0);
    check("rst_ovld",  32'(bus.out_valid), 32'd0);
    check("rst_sat",   32'(bus.sat),       32'd0);
    check("rst_busy",  32'(bus.busy),      32'd0);
    check("rst_ready", 32'(bus.in_ready),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(bus.in_ready), 32'd0);

    // 1) 0.5 + 8 * (1.0 * 2.0) = 16.5
    for (int i = 0; i < 8; i++) begin xv[i] = 16'h0100; wv[i] = 16'h0200; end
    run_op("c1", 16'h0080, xv, wv, 0, 16'h1080, 1'b0);
    check_pulse_end("c1", 16'h1080);

    // 2) saturation both directions
    for (int i = 0; i < 8; i++) begin xv[i] = 16'h7FFF; wv[i] = 16'h7FFF; end
    run_op("c2p", 16'h0000, xv, wv, 0, 16'h7FFF, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin xv[i] = 16'h8000; wv[i] = 16'h7FFF; end
    run_op("c2n", 16'h0000, xv, wv, 0, 16'h8000, 1'b1);
    @(negedge clk);

    // 3) rounding: a single nonzero pair, others zero
    xv = '0; wv = '0;
    xv[3] = 16'h0001; wv[3] = 16'h0080;
    run_op("c3a", 16'h0000, xv, wv, 0, 16'h0001, 1'b0);
    @(negedge clk);
    xv[3] = 16'hFFFF; wv[3] = 16'h0080;
    run_op("c3b", 16'h0000, xv, wv, 0, 16'h0000, 1'b0);
    @(negedge clk);
    xv[3] = 16'hFFFF; wv[3] = 16'h00C0;
    run_op("c3c", 16'h0000, xv, wv, 0, 16'hFFFF, 1'b0);
    @(negedge clk);

    // 4) stalls of 3 cycles between pairs, plus a mid-ACCUM start pulse
    for (int i = 0; i < 8; i++) begin xv[i] = 16'h0100; wv[i] = 16'h0200; end
    run_op("c4", 16'h0080, xv, wv, 3, 16'h1080, 1'b0);
    check_pulse_end("c4", 16'h1080);

    // 5) reset after 4 accepts abandons the operation
    bus.start = 1'b1;
    bus.bias  = 16'h0080;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.x_in     = 16'h0100;
      bus.w_in     = 16'h0200;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("c5_out",   32'(bus.out),      32'd0);
    check("c5_busy",  32'(bus.busy),     32'd0);
    check("c5_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 12; i++) begin
      check("c5_no_ovld", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
    end
    run_op("c5r", 16'h0080, xv, wv, 0, 16'h1080, 1'b0);
    t_first = cyc;

    // 6) back-to-back: start issued in the out_valid cycle; -8.0 expected
    for (int i = 0; i < 8; i++) begin xv[i] = 16'hFF00; wv[i] = 16'h0100; end
    run_op("c6", 16'h0000, xv, wv, 0, 16'hF800, 1'b0);
    check("c6_spacing", 32'(cyc - t_first), 32'd10);
    check_pulse_end("c6", 16'hF800);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
